parking_gate_sensor_decoder: RTL and testbench
==============================================

Name: parking_gate_sensor_decoder

Overview:
Front-end for the entry/exit control FSM. It reads two raw infrared beam sensors mounted in one gate lane and decodes the order in which a vehicle breaks them. It emits single-cycle entry_pulse and exit_pulse strobes, which feed the FSM's entry/exit inputs. It also flags malformed or stalled beam sequences so that ghost counts never reach the occupancy logic.

Parameters:
DEBOUNCE_CYCLES, 4, number of consecutive cycles a synchronized sensor value must differ from the stable value before it is accepted; legal range 1..255.
TIMEOUT_CYCLES, 4096, maximum cycles the decoder may stay in any in-progress state without a state change; must be greater than 2*DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous, active-low reset.
sensor_a_raw  input  1  outer beam, asynchronous; 1 = beam blocked.
sensor_b_raw  input  1  inner beam, asynchronous; 1 = beam blocked.
entry_pulse  output  1  one-cycle strobe: a vehicle completed the entry sequence.
exit_pulse  output  1  one-cycle strobe: a vehicle completed the exit sequence.
seq_fault  output  1  one-cycle strobe: illegal transition or timeout detected.
busy  output  1  high while the decoder state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs are 0.
  - Synchronizer flops, stable values and counters are 0.
  - FSM state is IDLE.
- Input path, per sensor:
  - 2-flop synchronizer.
  - Debounce: a counter increments while sync != stable and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with sync still != stable, stable takes the sync value on the next edge.
- Latency: a clean raw change produces its registered strobe exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the change.
- FSM. Notation is (a,b) = debounced (A,B). States: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, WAIT_CLEAR.
  - IDLE:
    - (1,0) -> IN_A.
    - (0,1) -> OUT_B.
    - (1,1) -> WAIT_CLEAR with seq_fault.
    - (0,0) stays in IDLE.
  - IN_A:
    - (1,1) -> IN_AB.
    - (0,1) -> IN_B.
    - (0,0) -> IDLE (back-out, no strobe).
  - IN_AB:
    - (0,1) -> IN_B.
    - (1,0) -> IN_A.
    - (0,0) -> WAIT_CLEAR with seq_fault.
  - IN_B:
    - (0,0) -> IDLE with entry_pulse.
    - (1,1) -> IN_AB.
    - (1,0) -> WAIT_CLEAR with seq_fault.
  - OUT_B, OUT_BA, OUT_A: mirror of IN_A, IN_AB, IN_B with a and b swapped. The completing transition OUT_A -> IDLE on (0,0) raises exit_pulse.
  - WAIT_CLEAR: (0,0) -> IDLE; no strobe; no timeout.
- Timeout:
  - A timer clears on every state change and in IDLE and WAIT_CLEAR.
  - It increments in all other states.
  - On reaching TIMEOUT_CYCLES-1 the FSM goes to WAIT_CLEAR and seq_fault is raised.
  - Timer width is clog2(TIMEOUT_CYCLES).
- Strobes:
  - All strobes are registered, high for exactly one cycle.
  - entry_pulse, exit_pulse and seq_fault are mutually exclusive.
- busy is registered and equals (state != IDLE).
- Both debounced inputs may change on the same edge. The FSM evaluates the new (a,b) pair exactly per the tables above; unlisted pairs hold the current state.
- Reset mid-sequence: the sequence is discarded and no strobe is produced. If the beams are still blocked after reset release, the debounced values rise from 0 and the FSM restarts from IDLE per the table.

Decomposition:
- parking_pkg holds:
  - the state encoding constants (3-bit) for the eight states;
  - the default DEBOUNCE_CYCLES and TIMEOUT_CYCLES;
  - the counter-width helper.
- One sub-module, sensor_debounce: synchronizer plus debounce, parameterized by DEBOUNCE_CYCLES, instantiated twice (A, B).
- The FSM and timeout logic sit in the top module.

Test Plan:
Bench settings: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64.
1. Entry: (A,B) = (1,0) x10, (1,1) x10, (0,1) x10, (0,0) -> exactly one entry_pulse, 7 edges after the final clear; exit_pulse and seq_fault stay 0; busy back to 0 on the same edge as the strobe.
2. Exit: (0,1), (1,1), (1,0), (0,0), each held 10 cycles -> exactly one exit_pulse; entry_pulse and seq_fault stay 0.
3. Glitch rejection: A high for 3 cycles only -> busy stays 0; no strobe.
4. Back-out: A blocked 10 cycles then cleared -> busy rises then falls; no strobe, no fault.
5. Timeout: A blocked for 100 cycles -> one seq_fault after 64 cycles in IN_A; busy stays 1 until A clears, then 0; no entry_pulse.
6. Reset mid-sequence: rst_n low while in IN_AB -> all outputs 0 immediately. Release with (1,1) still applied -> seq_fault 1 cycle, WAIT_CLEAR. Clear both beams -> IDLE with no strobe.

Source files
------------

// File: rtl/parking_pkg.sv
// ============================================================================
// Module  : parking_pkg
// Brief   : State encoding, default timing and width helper for the gate
//           lane sensor decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package parking_pkg;

    localparam int c_debounce_cycles_def = 4;
    localparam int c_timeout_cycles_def  = 4096;

    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_in_a       = 3'd1;
    localparam logic [2:0] c_st_in_ab      = 3'd2;
    localparam logic [2:0] c_st_in_b       = 3'd3;
    localparam logic [2:0] c_st_out_b      = 3'd4;
    localparam logic [2:0] c_st_out_ba     = 3'd5;
    localparam logic [2:0] c_st_out_a      = 3'd6;
    localparam logic [2:0] c_st_wait_clear = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE       = c_st_idle,
        ST_IN_A       = c_st_in_a,
        ST_IN_AB      = c_st_in_ab,
        ST_IN_B       = c_st_in_b,
        ST_OUT_B      = c_st_out_b,
        ST_OUT_BA     = c_st_out_ba,
        ST_OUT_A      = c_st_out_a,
        ST_WAIT_CLEAR = c_st_wait_clear
    } state_t;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sensor_debounce.sv
// ============================================================================
// Module  : sensor_debounce
// Brief   : Two-flop synchronizer followed by a consecutive-cycle debouncer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sensor_debounce
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles_def
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);

    localparam int             c_cw       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_stable;
    logic [c_cw-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            // Any cycle of agreement restarts the qualification window.
            if (r_sync2 != r_stable) begin
                if (r_cnt == c_cnt_last) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cw'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign stable = r_stable;

endmodule

`default_nettype wire

// File: rtl/parking_gate_sensor_decoder.sv
// ============================================================================
// Module  : parking_gate_sensor_decoder
// Brief   : Decodes beam-break order in a gate lane into entry/exit strobes,
//           flagging illegal or stalled sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_gate_sensor_decoder
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles_def,
    parameter int TIMEOUT_CYCLES  = c_timeout_cycles_def
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor_a_raw,
    input  logic sensor_b_raw,
    output logic entry_pulse,
    output logic exit_pulse,
    output logic seq_fault,
    output logic busy
);

    localparam int              c_tw       = cnt_width(TIMEOUT_CYCLES);
    localparam logic [c_tw-1:0] c_tmr_last = c_tw'(TIMEOUT_CYCLES - 1);

    logic            w_a;
    logic            w_b;
    state_t          r_state;
    state_t          w_next;
    logic [c_tw-1:0] r_timer;
    logic            w_entry;
    logic            w_exit;
    logic            w_fault;
    logic            w_timed;
    logic            r_entry;
    logic            r_exit;
    logic            r_fault;
    logic            r_busy;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (sensor_a_raw),
        .stable (w_a)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (sensor_b_raw),
        .stable (w_b)
    );

    assign w_timed = (r_state != ST_IDLE) && (r_state != ST_WAIT_CLEAR);

    always_comb begin
        w_next  = r_state;
        w_entry = 1'b0;
        w_exit  = 1'b0;
        w_fault = 1'b0;
        case (r_state)
            ST_IDLE: begin
                case ({w_a, w_b})
                    2'b10:   w_next = ST_IN_A;
                    2'b01:   w_next = ST_OUT_B;
                    2'b11:   begin w_next = ST_WAIT_CLEAR; w_fault = 1'b1; end
                    default: ;
                endcase
            end
            ST_IN_A: begin
                case ({w_a, w_b})
                    2'b11:   w_next = ST_IN_AB;
                    2'b01:   w_next = ST_IN_B;
                    2'b00:   w_next = ST_IDLE;
                    default: ;
                endcase
            end
            ST_IN_AB: begin
                case ({w_a, w_b})
                    2'b01:   w_next = ST_IN_B;
                    2'b10:   w_next = ST_IN_A;
                    2'b00:   begin w_next = ST_WAIT_CLEAR; w_fault = 1'b1; end
                    default: ;
                endcase
            end
            ST_IN_B: begin
                case ({w_a, w_b})
                    2'b00:   begin w_next = ST_IDLE; w_entry = 1'b1; end
                    2'b11:   w_next = ST_IN_AB;
                    2'b10:   begin w_next = ST_WAIT_CLEAR; w_fault = 1'b1; end
                    default: ;
                endcase
            end
            ST_OUT_B: begin
                case ({w_a, w_b})
                    2'b11:   w_next = ST_OUT_BA;
                    2'b10:   w_next = ST_OUT_A;
                    2'b00:   w_next = ST_IDLE;
                    default: ;
                endcase
            end
            ST_OUT_BA: begin
                case ({w_a, w_b})
                    2'b10:   w_next = ST_OUT_A;
                    2'b01:   w_next = ST_OUT_B;
                    2'b00:   begin w_next = ST_WAIT_CLEAR; w_fault = 1'b1; end
                    default: ;
                endcase
            end
            ST_OUT_A: begin
                case ({w_a, w_b})
                    2'b00:   begin w_next = ST_IDLE; w_exit = 1'b1; end
                    2'b11:   w_next = ST_OUT_BA;
                    2'b01:   begin w_next = ST_WAIT_CLEAR; w_fault = 1'b1; end
                    default: ;
                endcase
            end
            ST_WAIT_CLEAR: begin
                if ({w_a, w_b} == 2'b00) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        // A stall only counts when the beams have not moved the FSM this cycle.
        if (w_timed && (w_next == r_state) && (r_timer == c_tmr_last)) begin
            w_next  = ST_WAIT_CLEAR;
            w_fault = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_entry <= 1'b0;
            r_exit  <= 1'b0;
            r_fault <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_entry <= w_entry;
            r_exit  <= w_exit;
            r_fault <= w_fault;
            r_busy  <= (w_next != ST_IDLE);
            if (!w_timed || (w_next != r_state)) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + c_tw'(1);
            end
        end
    end

    assign entry_pulse = r_entry;
    assign exit_pulse  = r_exit;
    assign seq_fault   = r_fault;
    assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_parking_gate_sensor_decoder.sv
// ============================================================================
// Module  : tb_parking_gate_sensor_decoder
// Brief   : Directed self-checking bench for the gate lane sensor decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_gate_sensor_decoder;

    logic clk;
    logic rst_n;
    logic sensor_a_raw;
    logic sensor_b_raw;
    logic entry_pulse;
    logic exit_pulse;
    logic seq_fault;
    logic busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_entry  = 0;
    int n_exit   = 0;
    int n_fault  = 0;
    int n_busy   = 0;
    int cyc      = 0;
    int first_fault = -1;

    parking_gate_sensor_decoder #(
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sensor_a_raw (sensor_a_raw),
        .sensor_b_raw (sensor_b_raw),
        .entry_pulse  (entry_pulse),
        .exit_pulse   (exit_pulse),
        .seq_fault    (seq_fault),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_entry = 0; n_exit = 0; n_fault = 0; n_busy = 0;
        cyc = 0; first_fault = -1;
    endtask

    // One clock, then sample just after the edge and tally strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (entry_pulse) n_entry++;
        if (exit_pulse)  n_exit++;
        if (seq_fault) begin
            n_fault++;
            if (first_fault < 0) first_fault = cyc;
        end
        if (busy) n_busy++;
    endtask

    task automatic hold(input logic a, input logic b, input int n);
        sensor_a_raw = a;
        sensor_b_raw = b;
        repeat (n) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        sensor_a_raw = 1'b0;
        sensor_b_raw = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", {entry_pulse, exit_pulse, seq_fault, busy}, 0);
        rst_n = 1'b1;
        hold(0, 0, 5);

        // Entry sequence with exact strobe latency on the final clear
        clear_counts();
        hold(1, 0, 10);
        hold(1, 1, 10);
        hold(0, 1, 10);
        sensor_a_raw = 1'b0;
        sensor_b_raw = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) begin
                check_eq("entry_not_early", entry_pulse, 0);
                check_eq("busy_before_entry", busy, 1);
            end
            if (k == 7) begin
                check_eq("entry_at_7", entry_pulse, 1);
                check_eq("busy_drop_with_entry", busy, 0);
            end
        end
        hold(0, 0, 10);
        check_eq("entry_count", n_entry, 1);
        check_eq("entry_no_exit", n_exit, 0);
        check_eq("entry_no_fault", n_fault, 0);

        // Exit sequence
        clear_counts();
        hold(0, 1, 10);
        hold(1, 1, 10);
        hold(1, 0, 10);
        hold(0, 0, 20);
        check_eq("exit_count", n_exit, 1);
        check_eq("exit_no_entry", n_entry, 0);
        check_eq("exit_no_fault", n_fault, 0);
        check_eq("exit_idle", busy, 0);

        // Three-cycle glitch must be filtered out
        clear_counts();
        hold(1, 0, 3);
        hold(0, 0, 15);
        check_eq("glitch_busy", n_busy, 0);
        check_eq("glitch_strobes", n_entry + n_exit + n_fault, 0);

        // Back-out from IN_A
        clear_counts();
        hold(1, 0, 10);
        check_eq("backout_busy_high", busy, 1);
        hold(0, 0, 10);
        check_eq("backout_busy_low", busy, 0);
        check_eq("backout_strobes", n_entry + n_exit + n_fault, 0);

        // Stall in IN_A: state entered at cycle 7, fault 64 cycles later
        clear_counts();
        hold(1, 0, 100);
        check_eq("timeout_fault_count", n_fault, 1);
        check_eq("timeout_fault_cycle", first_fault, 71);
        check_eq("timeout_busy_held", busy, 1);
        hold(0, 0, 10);
        check_eq("timeout_busy_clear", busy, 0);
        check_eq("timeout_no_entry", n_entry, 0);
        check_eq("timeout_fault_once", n_fault, 1);

        // Reset while in IN_AB, then release with both beams still blocked
        clear_counts();
        hold(1, 0, 10);
        hold(1, 1, 10);
        check_eq("inab_busy", busy, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_outputs", {entry_pulse, exit_pulse, seq_fault, busy}, 0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_held_outputs", {entry_pulse, exit_pulse, seq_fault, busy}, 0);
        rst_n = 1'b1;
        clear_counts();
        hold(1, 1, 10);
        check_eq("post_reset_fault", n_fault, 1);
        check_eq("post_reset_fault_cycle", first_fault, 7);
        check_eq("post_reset_wait_busy", busy, 1);
        hold(0, 0, 10);
        check_eq("post_reset_idle", busy, 0);
        check_eq("post_reset_no_strobe", n_entry + n_exit, 0);
        check_eq("post_reset_fault_once", n_fault, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
